// File: rtl/sysid_regbank_if.sv
// Avalon-MM slave bus for the system-ID / housekeeping register bank.
// Handshake: the slave never stalls; read or write is accepted in the cycle it is high,
// and each accepted read returns exactly one readdatavalid pulse, in order.
interface sysid_regbank_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regbank.sv
// System ID, build timestamp, capability word, coherent 64-bit uptime counter and
// software scratch registers behind a non-stalling Avalon-MM slave with fixed read latency.
module sysid_regbank #(
    parameter logic [31:0] SYSTEM_ID    = 32'h00000000,
    parameter logic [31:0] TIMESTAMP    = 32'h00000000,
    parameter int          ADDR_W       = 4,
    parameter int          NUM_SCRATCH  = 4,
    parameter int          READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    sysid_regbank_if.slave    bus
);
    localparam logic [31:0] CAPS = {16'h0, 4'(NUM_SCRATCH), 4'(READ_LATENCY), 8'(ADDR_W)};

    logic [31:0] word_idx;
    logic        rd_accept;
    logic        uptime_clr;
    logic [63:0] uptime;
    logic [31:0] uptime_hi_shadow;
    logic [31:0] scratch [NUM_SCRATCH];
    logic [31:0] rd_mux;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_data [READ_LATENCY];

    assign word_idx   = 32'(bus.address);
    // A read that coincides with a write is dropped; the write wins.
    assign rd_accept  = bus.read && !bus.write;
    assign uptime_clr = bus.write && (word_idx == 32'd2) && (|bus.byteenable);

    // The clearing edge counts as tick zero, so the following cycle samples 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime <= '0;
        end else if (uptime_clr) begin
            uptime <= 64'd1;
        end else begin
            uptime <= uptime + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_hi_shadow <= '0;
        end else if (rd_accept && (word_idx == 32'd2)) begin
            uptime_hi_shadow <= uptime[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else if (bus.write) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (word_idx == 32'(8 + i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.byteenable[b]) scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word_idx)
            32'd0:   rd_mux = SYSTEM_ID;
            32'd1:   rd_mux = TIMESTAMP;
            32'd2:   rd_mux = uptime[31:0];
            32'd3:   rd_mux = uptime_hi_shadow;
            32'd4:   rd_mux = CAPS;
            default: rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (word_idx == 32'(8 + i)) rd_mux = scratch[i];
        end
    end

    // Data stages load only behind a valid so readdata holds its last returned value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) pipe_data[k] <= '0;
        end else begin
            pipe_vld[0] <= rd_accept;
            if (rd_accept) pipe_data[0] <= rd_mux;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    assign bus.readdata      = pipe_data[READ_LATENCY-1];
    assign bus.readdatavalid = pipe_vld[READ_LATENCY-1];
endmodule

// File: tb/tb_sysid_regbank.sv
// Bench for sysid_regbank: two instances (read latency 2 and 3) driven by the same bus
// traffic and scored against a register-level model of the map.
module tb_sysid_regbank;
    localparam logic [31:0] SID  = 32'h514A5B38;
    localparam logic [31:0] TS   = 32'h4CB1F0A0;
    localparam int          NS   = 4;
    localparam int          AW   = 4;
    localparam int          RL_A = 2;
    localparam int          RL_B = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    sysid_regbank_if #(.ADDR_W(AW)) bus_a ();
    sysid_regbank_if #(.ADDR_W(AW)) bus_b ();

    sysid_regbank #(.SYSTEM_ID(SID), .TIMESTAMP(TS), .ADDR_W(AW), .NUM_SCRATCH(NS),
                    .READ_LATENCY(RL_A)) dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
    sysid_regbank #(.SYSTEM_ID(SID), .TIMESTAMP(TS), .ADDR_W(AW), .NUM_SCRATCH(NS),
                    .READ_LATENCY(RL_B)) dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

    // Reference state: what software would see in each register this cycle.
    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic [31:0] m_scr [NS];
    // Expected read returns: {cycle the pulse is due, data}.
    logic [63:0] exp_q_a[$];
    logic [63:0] exp_q_b[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input int addr, input int lat);
        if (addr == 0) return SID;
        if (addr == 1) return TS;
        if (addr == 2) return m_cnt[31:0];
        if (addr == 3) return m_shadow;
        if (addr == 4) return 32'((NS << 12) + (lat << 8) + AW);
        if (addr >= 8 && addr < 8 + NS) return m_scr[addr-8];
        return 32'd0;
    endfunction

    task automatic monitor();
        logic due_a, due_b;
        due_a = (exp_q_a.size() > 0) && (exp_q_a[0][63:32] == 32'(cyc));
        due_b = (exp_q_b.size() > 0) && (exp_q_b[0][63:32] == 32'(cyc));
        if (due_a || bus_a.readdatavalid) begin
            check_eq("rdv_a", 32'(bus_a.readdatavalid), 32'(due_a));
            if (due_a) begin
                check_eq("rdata_a", bus_a.readdata, exp_q_a[0][31:0]);
                void'(exp_q_a.pop_front());
            end
        end
        if (due_b || bus_b.readdatavalid) begin
            check_eq("rdv_b", 32'(bus_b.readdatavalid), 32'(due_b));
            if (due_b) begin
                check_eq("rdata_b", bus_b.readdata, exp_q_b[0][31:0]);
                void'(exp_q_b.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        monitor();
    endtask

    task automatic set_bus(input logic rd, input logic wr, input int addr,
                           input logic [31:0] wd, input logic [3:0] be);
        bus_a.read = rd;  bus_a.write = wr;  bus_a.address = AW'(addr);
        bus_a.writedata = wd;  bus_a.byteenable = be;
        bus_b.read = rd;  bus_b.write = wr;  bus_b.address = AW'(addr);
        bus_b.writedata = wd;  bus_b.byteenable = be;
    endtask

    // One bus cycle: predict its effect on the register map, then clock it.
    task automatic bus_cycle(input logic rd, input logic wr, input int addr,
                             input logic [31:0] wd, input logic [3:0] be);
        set_bus(rd, wr, addr, wd, be);
        if (rd && !wr) begin
            exp_q_a.push_back({32'(cyc + RL_A), model_read(addr, RL_A)});
            exp_q_b.push_back({32'(cyc + RL_B), model_read(addr, RL_B)});
            if (addr == 2) m_shadow = m_cnt[63:32];
        end
        if (wr && addr >= 8 && addr < 8 + NS) begin
            for (int b = 0; b < 4; b++) if (be[b]) m_scr[addr-8][8*b +: 8] = wd[8*b +: 8];
        end
        // A clear zeroes the counter at the write edge; the next cycle already sees 1.
        if (wr && addr == 2 && be != 4'd0) m_cnt = 64'd0 + 64'd1;
        else m_cnt = m_cnt + 64'd1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 0, 32'd0, 4'd0);
    endtask

    task automatic pulse_reset(input int n);
        reset_n = 1'b0;
        #1;
        check_eq("rst_rdv_a", 32'(bus_a.readdatavalid), 32'd0);
        check_eq("rst_rdv_b", 32'(bus_b.readdatavalid), 32'd0);
        check_eq("rst_rdata_a", bus_a.readdata, 32'd0);
        check_eq("rst_rdata_b", bus_b.readdata, 32'd0);
        set_bus(1'b0, 1'b0, 0, 32'd0, 4'd0);
        exp_q_a.delete();
        exp_q_b.delete();
        m_cnt = '0;
        m_shadow = '0;
        for (int i = 0; i < NS; i++) m_scr[i] = '0;
        for (int i = 0; i < n; i++) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        set_bus(1'b0, 1'b0, 0, 32'd0, 4'd0);
        pulse_reset(3);

        // Identity words back to back.
        bus_cycle(1'b1, 1'b0, 0, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 1, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 4, 32'd0, 4'd0);
        idle(4);

        // Byte-lane scratch writes and an unmapped word.
        bus_cycle(1'b0, 1'b1, 8, 32'hDEADBEEF, 4'b1111);
        bus_cycle(1'b0, 1'b1, 8, 32'h11223344, 4'b0101);
        bus_cycle(1'b1, 1'b0, 8, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 12, 32'd0, 4'd0);
        idle(4);

        // Low-word carry into the high word, then the shadow must still hold the old high.
        force dut_a.uptime = 64'h00000001_FFFFFFFF;
        force dut_b.uptime = 64'h00000001_FFFFFFFF;
        #1;
        release dut_a.uptime;
        release dut_b.uptime;
        m_cnt = 64'h00000001_FFFFFFFF;
        bus_cycle(1'b1, 1'b0, 2, 32'd0, 4'd0);
        idle(4);
        bus_cycle(1'b1, 1'b0, 3, 32'd0, 4'd0);
        idle(4);

        // Counter clear, and a zero-byteenable write that must not clear.
        bus_cycle(1'b0, 1'b1, 2, 32'hFFFFFFFF, 4'hF);
        bus_cycle(1'b1, 1'b0, 2, 32'd0, 4'd0);
        bus_cycle(1'b0, 1'b1, 2, 32'hFFFFFFFF, 4'h0);
        bus_cycle(1'b1, 1'b0, 2, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 3, 32'd0, 4'd0);
        idle(4);

        // Simultaneous read and write: write lands, read returns nothing.
        bus_cycle(1'b1, 1'b1, 9, 32'hA5A5A5A5, 4'hF);
        idle(4);
        bus_cycle(1'b1, 1'b0, 9, 32'd0, 4'd0);
        idle(4);

        // Random traffic over the whole map.
        for (int n = 0; n < 600; n++) begin
            int op, addr;
            logic [31:0] wd;
            logic [3:0] be;
            op   = int'($urandom_range(0, 9));
            addr = int'($urandom_range(0, 15));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            if (addr == 2 && op >= 4 && $urandom_range(0, 3) != 0) addr = 3;
            bus_cycle(op < 5, op >= 4 && op < 8, addr, wd, be);
        end
        idle(4);

        // Reset in the middle of a read burst: nothing issued before it may return.
        bus_cycle(1'b1, 1'b0, 8, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 0, 32'd0, 4'd0);
        set_bus(1'b1, 1'b0, 4, 32'd0, 4'd0);
        pulse_reset(3);
        bus_cycle(1'b1, 1'b0, 2, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 8, 32'd0, 4'd0);
        bus_cycle(1'b1, 1'b0, 3, 32'd0, 4'd0);
        idle(8);

        check_eq("drain_a", 32'(exp_q_a.size()), 32'd0);
        check_eq("drain_b", 32'(exp_q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sysid_regbank.md
Name: sysid_regbank

Overview:
- Parametrised Avalon-MM system-identification and housekeeping slave; successor to the single-word system ID slave.
- Exposes the following registers:
  - constant system ID
  - build timestamp
  - capability word
  - coherent 64-bit free-running uptime counter
  - NUM_SCRATCH software-writable scratch registers
- Sits on the Nios II data master interconnect.
- Software uses it to check hardware/software build compatibility, measure elapsed cycles, and hold boot-handshake values.

Parameters:
- SYSTEM_ID, 32'h00000000, value returned at word 0
- TIMESTAMP, 32'h00000000, build timestamp returned at word 1
- ADDR_W, 4, word-address width (16 words)
- NUM_SCRATCH, 4, number of 32-bit scratch registers, 1..8, mapped at words 8..8+NUM_SCRATCH-1
- READ_LATENCY, 1, cycles from accepted read to readdatavalid, 1..3

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  ADDR_W  word address
- read  input  1  read strobe
- write  input  1  write strobe
- writedata  input  32  write data
- byteenable  input  4  byte lanes for writes
- readdata  output  32  read data, valid with readdatavalid
- readdatavalid  output  1  one-cycle pulse per accepted read

Behaviour:
- Interface is fixed as decided: one clock (clock); reset_n is asynchronous and active-low.
- Reset values:
  - readdata = 0, readdatavalid = 0
  - uptime counter = 0, high shadow = 0
  - all scratch registers = 0
  - read pipeline flushed
- The slave never stalls. Every read is accepted in its cycle. Back-to-back reads are allowed every cycle.
- Register map (word address):
  - 0 SYSTEM_ID, RO
  - 1 TIMESTAMP, RO
  - 2 UPTIME_LO, RO; any write clears the counter
  - 3 UPTIME_HI_SHADOW, RO
  - 4 CAPS, RO = {16'h0, 4'(NUM_SCRATCH), 4'(READ_LATENCY), 8'(ADDR_W)}
  - 8.. scratch, RW
  - All other addresses read 0; writes to them are ignored.
- Uptime counter:
  - 64-bit; increments by 1 every clock after reset release.
  - Wraps from 2^64-1 to 0.
- Coherent snapshot:
  - A read of word 2 returns counter[31:0] as sampled in the read cycle.
  - In that same edge, counter[63:32] is latched into the high shadow.
  - A read of word 3 returns the shadow, not the live high word.
  - The shadow changes only on a word-2 read or reset.
- Counter clear:
  - A write to word 2 with any byteenable bit set zeroes the counter at that edge.
  - The counter reads 1 on the next cycle's sample. The shadow is not changed.
  - A write to word 2 with byteenable = 0 has no effect.
- Scratch writes:
  - Each byte lane i is updated only when byteenable[i] = 1.
  - Writes to RO words are ignored.
- Read pipeline:
  - Read data is selected and captured at the accepting edge.
  - It is then delayed through READ_LATENCY-1 further register stages.
  - readdatavalid rises exactly READ_LATENCY cycles after the read cycle, for one cycle.
  - Reads complete in order.
- readdata when readdatavalid = 0 holds its last value. It is don't-care to the master.
- Read and write asserted together: the write is performed; the read is dropped (no readdatavalid).
- Read of a scratch word in the cycle after a write to it returns the new value.
- Reset asserted mid-pipeline:
  - In-flight reads are discarded.
  - readdatavalid deasserts asynchronously.
  - No pulse is emitted after release for reads issued before reset.

Test Plan:
- Reset, then read words 0,1,4 back-to-back with SYSTEM_ID=32'h514A5B38, TIMESTAMP=32'h4CB1F0A0, READ_LATENCY=2, NUM_SCRATCH=4, ADDR_W=4 -> readdatavalid pulses on cycles +2,+3,+4 with 514A5B38, 4CB1F0A0, 00004204.
- Write 32'hDEADBEEF to word 8 with byteenable=4'b1111, then write 32'h11223344 with byteenable=4'b0101, then read word 8 -> 32'hDE22BE44; read word 12 -> 0.
- Force counter to 64'h00000001_FFFFFFFF, read word 2 then, 5 cycles later, word 3 -> FFFFFFFF then 00000001. The live high word is 2 by then; the shadow still returns 1.
- Write to word 2 (byteenable=4'hF), then read word 2 on the next cycle -> 00000001. Write to word 2 with byteenable=0 -> counter keeps counting.
- Assert read and write of word 9 in the same cycle with writedata=32'hA5A5A5A5 -> no readdatavalid; subsequent read returns A5A5A5A5.
- Issue 3 back-to-back reads with READ_LATENCY=3, pulse reset_n low after the 2nd read cycle -> readdatavalid = 0 immediately and no pulses after release; counter and scratch read 0 afterward.
